// File: rtl/btn_debounce.sv
// btn_debounce: button conditioning front end.
// Each raw button passes through a two-flop synchroniser and then a per-button
// debounce FSM (LOW / CHK_HIGH / HIGH / CHK_LOW) with a stability counter.
// The outputs are a clean registered level plus one-cycle press and release pulses.
// Optional feature: define BTN_DEBOUNCE_REPEAT_EN to build per-button hold counters
// that add auto-repeat pulses to btn_press while a button stays pressed.
module btn_debounce #(
  parameter int N               = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release
);

  // Stability counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 bits suffice.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // A single check state needs at least two samples to mean anything.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
  end

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } state_t;

  logic [N-1:0]     s1;
  logic [N-1:0]     s2;
  state_t           state     [N];
  state_t           state_nxt [N];
  logic [CNT_W-1:0] cnt       [N];
  logic [CNT_W-1:0] cnt_nxt   [N];
  logic [N-1:0]     level_nxt;
  logic [N-1:0]     rise_nxt;
  logic [N-1:0]     fall_nxt;
  logic [N-1:0]     rep_fire;

  // Two-flop synchroniser, nothing between the flops; s2 is the usable sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // FSM state and stability counter registers; reset discards any pending change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        state[i] <= ST_LOW;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // Next-state logic: any sample disagreeing with the candidate level restarts the check.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        ST_LOW: begin
          if (s2[i]) begin
            state_nxt[i] = ST_CHK_HIGH;
            cnt_nxt[i]   = CNT_ONE;
          end else begin
            cnt_nxt[i]   = '0;
          end
        end
        ST_CHK_HIGH: begin
          if (!s2[i]) begin
            state_nxt[i] = ST_LOW;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = ST_HIGH;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i]   = cnt[i] + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!s2[i]) begin
            state_nxt[i] = ST_CHK_LOW;
            cnt_nxt[i]   = CNT_ONE;
          end else begin
            cnt_nxt[i]   = '0;
          end
        end
        ST_CHK_LOW: begin
          if (s2[i]) begin
            state_nxt[i] = ST_HIGH;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = ST_LOW;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i]   = cnt[i] + CNT_ONE;
          end
        end
        default: begin
          state_nxt[i] = ST_LOW;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so level and its edge pulses register together.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      level_nxt[i] = (state_nxt[i] == ST_HIGH) || (state_nxt[i] == ST_CHK_LOW);
    end
    rise_nxt = level_nxt & ~btn_level;
    fall_nxt = ~level_nxt & btn_level;
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_ONE     = REP_W'(1);

  logic [REP_W-1:0] hold_cnt     [N];
  logic [REP_W-1:0] hold_cnt_nxt [N];
  logic [N-1:0]     hold_rep;
  logic [N-1:0]     hold_rep_nxt;

  // Hold timing: first wait REPEAT_DELAY after the press, then fire every REPEAT_PERIOD.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      hold_cnt_nxt[i] = hold_cnt[i];
      hold_rep_nxt[i] = hold_rep[i];
      rep_fire[i]     = 1'b0;
      if (!level_nxt[i]) begin
        // Off the HIGH side (including the release edge): no repeats, stay cleared.
        hold_cnt_nxt[i] = '0;
        hold_rep_nxt[i] = 1'b0;
      end else if (!btn_level[i]) begin
        // Entry to HIGH: the initial press pulse is cycle zero of the hold.
        hold_cnt_nxt[i] = '0;
        hold_rep_nxt[i] = 1'b0;
      end else if (!hold_rep[i]) begin
        if (hold_cnt[i] == DELAY_LAST) begin
          rep_fire[i]     = 1'b1;
          hold_cnt_nxt[i] = '0;
          hold_rep_nxt[i] = 1'b1;
        end else begin
          hold_cnt_nxt[i] = hold_cnt[i] + REP_ONE;
        end
      end else begin
        if (hold_cnt[i] == PERIOD_LAST) begin
          rep_fire[i]     = 1'b1;
          hold_cnt_nxt[i] = '0;
        end else begin
          hold_cnt_nxt[i] = hold_cnt[i] + REP_ONE;
        end
      end
    end
  end

  // Hold counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        hold_cnt[i] <= '0;
      end
      hold_rep <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        hold_cnt[i] <= hold_cnt_nxt[i];
      end
      hold_rep <= hold_rep_nxt;
    end
  end
`else
  assign rep_fire = '0;
`endif

  // Registered outputs: level plus one-cycle pulses coincident with its change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_level   <= level_nxt;
      btn_press   <= rise_nxt | rep_fire;
      btn_release <= fall_nxt;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios followed by a randomized stretch,
// all checked against a run-length reference model of the debounce rules.
module tb_btn_debounce;

  localparam int N  = 3;
  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;
`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  btn_debounce #(
    .N(N), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model: h1/h2 hold the input as sampled one and two edges ago;
  // run counts consecutive samples disagreeing with the accepted level.
  logic [N-1:0] m_h1, m_h2, m_lvl, m_press, m_rel;
  int           m_run  [N];
  int           m_hold [N];

  task automatic model_reset();
    m_h1 = '0; m_h2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i]  = 0;
      m_hold[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] b);
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < N; i++) begin
      if (m_h2[i] != m_lvl[i]) m_run[i]++;
      else                     m_run[i] = 0;
      if (m_run[i] == DC) begin
        m_run[i] = 0;
        m_lvl[i] = ~m_lvl[i];
        if (m_lvl[i]) begin
          m_press[i] = 1'b1;
          m_hold[i]  = 0;
        end else begin
          m_rel[i] = 1'b1;
        end
      end else if (m_lvl[i]) begin
        m_hold[i]++;
        if (REP_ON && m_hold[i] >= RD && ((m_hold[i] - RD) % RP) == 0) m_press[i] = 1'b1;
      end
    end
    m_h2 = m_h1;
    m_h1 = b;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] b, input string tag);
    btn = b;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(b);
    #1;
    chk({tag, "_level"},   32'(btn_level),   32'(m_lvl));
    chk({tag, "_press"},   32'(btn_press),   32'(m_press));
    chk({tag, "_release"}, 32'(btn_release), 32'(m_rel));
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_level"},   32'(btn_level),   32'(0));
    chk({tag, "_press"},   32'(btn_press),   32'(0));
    chk({tag, "_release"}, 32'(btn_release), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cnt_a, cnt_b, cnt_c, first_k, act;
    int           rem [N];
    int           glitch [3];
    logic [N-1:0] cur;

    model_reset();
    btn = '1;
    #2 rst = 1'b1;

    // Scenario 1: all buttons held through reset, accepted 6 edges after release.
    for (int k = 0; k < 3; k++) step('1, "s1_in_rst");
    chk("s1_level_in_rst", 32'(btn_level), 32'(0));
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step('1, "s1_after_rst");
      if (k < 6) chk("s1_level_pending", 32'(btn_level), 32'(0));
    end
    chk("s1_level_accept", 32'(btn_level), 32'(3'b111));
    chk("s1_press_accept", 32'(btn_press), 32'(3'b111));
    step('1, "s1_hold");
    chk("s1_press_single", 32'(btn_press), 32'(0));
    for (int k = 0; k < 8; k++) step('0, "s1_drop");

    // Scenario 2: clean 20-cycle press on btn[0].
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 0; k < 30; k++) begin
      step((k < 20) ? 3'b001 : 3'b000, "s2");
      cnt_a += int'(btn_level[0]);
      cnt_b += int'(btn_press[0]);
      cnt_c += int'(btn_release[0]);
    end
    chk("s2_level_cycles", 32'(cnt_a), 32'(20));
    chk("s2_press_count",  32'(cnt_b), 32'(1));
    chk("s2_release_count", 32'(cnt_c), 32'(1));

    // Scenario 3: bounce on btn[1], then a steady press.
    step(3'b010, "s3_bounce"); step(3'b000, "s3_bounce");
    step(3'b010, "s3_bounce"); step(3'b000, "s3_bounce");
    first_k = -1;
    for (int k = 1; k <= 12; k++) begin
      step(3'b010, "s3_steady");
      if (first_k < 0 && btn_level[1]) first_k = k;
    end
    chk("s3_rise_edge", 32'(first_k), 32'(6));
    for (int k = 0; k < 8; k++) step('0, "s3_drop");

    // Scenario 4: short glitches on btn[2] must never be accepted.
    glitch = '{1, 2, 3};
    act = 0;
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < glitch[g]; k++) begin
        step(3'b100, "s4_glitch");
        act |= int'(btn_level[2] | btn_press[2] | btn_release[2]);
      end
      for (int k = 0; k < 6; k++) begin
        step(3'b000, "s4_quiet");
        act |= int'(btn_level[2] | btn_press[2] | btn_release[2]);
      end
    end
    chk("s4_activity", 32'(act), 32'(0));

    // Scenario 5: simultaneous press, then reset while the release is being checked.
    for (int k = 0; k < 6; k++) step(3'b101, "s5_press");
    chk("s5_press_pair", 32'(btn_press), 32'(3'b101));
    chk("s5_level_pair", 32'(btn_level), 32'(3'b101));
    for (int k = 0; k < 4; k++) step(3'b000, "s5_chk_low");
    chk("s5_level_pending", 32'(btn_level), 32'(3'b101));
    async_reset("s5_async_rst");
    for (int k = 0; k < 2; k++) step(3'b000, "s5_in_rst");
    rst = 1'b0;
    cnt_c = 0;
    for (int k = 0; k < 10; k++) begin
      step(3'b000, "s5_after_rst");
      cnt_c += int'(|btn_release);
    end
    chk("s5_no_release", 32'(cnt_c), 32'(0));

    // Scenario 6: long hold on btn[0]; repeats only in the repeat build.
    for (int k = 0; k < 6; k++) step(3'b001, "s6_press");
    chk("s6_level_accept", 32'(btn_level[0]), 32'(1));
    cnt_b = int'(btn_press[0]);
    for (int k = 1; k < 50; k++) begin
      step(3'b001, "s6_hold");
      cnt_b += int'(btn_press[0]);
    end
    chk("s6_press_count", 32'(cnt_b), REP_ON ? 32'(5) : 32'(1));
    first_k = -1;
    for (int k = 1; k <= 20; k++) begin
      step(3'b000, "s6_drop");
      if (!btn_level[0]) begin
        first_k = k;
        break;
      end
    end
    chk("s6_release_edge", 32'(first_k), 32'(6));
    cnt_b = int'(btn_press[0]);
    for (int k = 0; k < 30; k++) begin
      step(3'b000, "s6_after");
      cnt_b += int'(btn_press[0]);
    end
    chk("s6_press_after_release", 32'(cnt_b), 32'(0));

    // Randomized stretch: independent bouncy buttons with a reset in the middle.
    cur = '0;
    for (int i = 0; i < N; i++) rem[i] = int'($urandom_range(1, 9));
    for (int s = 0; s < 400; s++) begin
      if (s == 200) begin
        async_reset("rnd_async_rst");
        for (int k = 0; k < 2; k++) step(cur, "rnd_in_rst");
        rst = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          cur[i] = ~cur[i];
          rem[i] = int'($urandom_range(1, 9));
        end
        rem[i]--;
      end
      step(cur, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
